// File: rtl/id_exe_stage_reg_pkg.sv
// id_exe_stage_reg_pkg: shared widths, EXE command encodings, status flag indices and bubble constant
package id_exe_stage_reg_pkg;
  localparam int WORD_W_DEF = 32;
  localparam int REG_AW_DEF = 4;
  localparam int CMD_W_DEF  = 4;
  typedef enum logic [CMD_W_DEF-1:0] {
    CMD_NOP = 4'd0,
    CMD_MOV = 4'd1,
    CMD_ADD = 4'd2,
    CMD_ADC = 4'd3,
    CMD_SUB = 4'd4,
    CMD_SBC = 4'd5,
    CMD_AND = 4'd6,
    CMD_ORR = 4'd7,
    CMD_EOR = 4'd8,
    CMD_MVN = 4'd9
  } exe_cmd_e;
  localparam int SR_N = 3;
  localparam int SR_Z = 2;
  localparam int SR_C = 1;
  localparam int SR_V = 0;
  typedef struct packed {
    logic     wb_en;
    logic     mem_r_en;
    logic     mem_w_en;
    logic     b;
    logic     s;
    logic     imm;
    exe_cmd_e exe_cmd;
  } ctrl_t;
  // a bubble carries no side-effect enables and a NOP command
  localparam ctrl_t CTRL_BUBBLE = '{wb_en: 1'b0, mem_r_en: 1'b0, mem_w_en: 1'b0,
                                    b: 1'b0, s: 1'b0, imm: 1'b0, exe_cmd: CMD_NOP};
endpackage

// File: rtl/id_exe_stage_reg_pipe_reg.sv
// pipe_reg: W-bit register with async active-low reset, sync clear to CLR_VAL and load enable
module pipe_reg #(
  parameter int           W       = 1,
  parameter logic [W-1:0] CLR_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= '0;
    else if (clr) q <= CLR_VAL;
    else if (en) q <= d;
endmodule

// File: rtl/id_exe_stage_reg.sv
// id_exe_stage_reg: ID/EXE pipeline register with hazard freeze and branch-flush bubble insertion
module id_exe_stage_reg
  import id_exe_stage_reg_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF,
  parameter int REG_AW = REG_AW_DEF,
  parameter int CMD_W  = CMD_W_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              FREEZE,
  input  logic              FLUSH,
  input  logic [WORD_W-1:0] PC_In,
  input  logic              WB_EN_In,
  input  logic              MEM_R_EN_In,
  input  logic              MEM_W_EN_In,
  input  logic              B_In,
  input  logic              S_In,
  input  logic [CMD_W-1:0]  EXE_CMD_In,
  input  logic [WORD_W-1:0] Val_Rn_In,
  input  logic [WORD_W-1:0] Val_Rm_In,
  input  logic              imm_In,
  input  logic [11:0]       Shift_operand_In,
  input  logic [23:0]       Signed_imm_24_In,
  input  logic [REG_AW-1:0] Dest_In,
  input  logic [REG_AW-1:0] src1_In,
  input  logic [REG_AW-1:0] src2_In,
  input  logic [3:0]        SR_In,
  output logic [WORD_W-1:0] PC_Out,
  output logic              WB_EN_Out,
  output logic              MEM_R_EN_Out,
  output logic              MEM_W_EN_Out,
  output logic              B_Out,
  output logic              S_Out,
  output logic [CMD_W-1:0]  EXE_CMD_Out,
  output logic [WORD_W-1:0] Val_Rn_Out,
  output logic [WORD_W-1:0] Val_Rm_Out,
  output logic              imm_Out,
  output logic [11:0]       Shift_operand_Out,
  output logic [23:0]       Signed_imm_24_Out,
  output logic [REG_AW-1:0] Dest_Out,
  output logic [REG_AW-1:0] src1_Out,
  output logic [REG_AW-1:0] src2_Out,
  output logic [3:0]        SR_Out,
  output logic              Valid_Out
);
  localparam int CW = 6 + CMD_W;
  localparam int DW = 2 * WORD_W;
  localparam int TW = 3 * REG_AW;
  logic          en;
  logic [CW-1:0] ctrl_q;
  logic [DW-1:0] data_q;
  logic [35:0]   imm_q;
  logic [TW-1:0] tag_q;
  // flush must still clock through a frozen stage, so it overrides the hold
  assign en = ~FREEZE | FLUSH;
  pipe_reg #(.W(CW), .CLR_VAL(CW'(CTRL_BUBBLE))) u_ctrl (
    .clk(CLK), .rst_n(RST), .clr(FLUSH), .en(en),
    .d({WB_EN_In, MEM_R_EN_In, MEM_W_EN_In, B_In, S_In, imm_In, EXE_CMD_In}),
    .q(ctrl_q)
  );
  pipe_reg #(.W(DW)) u_data (
    .clk(CLK), .rst_n(RST), .clr(FLUSH), .en(en),
    .d({Val_Rn_In, Val_Rm_In}), .q(data_q)
  );
  pipe_reg #(.W(36)) u_imm (
    .clk(CLK), .rst_n(RST), .clr(FLUSH), .en(en),
    .d({Shift_operand_In, Signed_imm_24_In}), .q(imm_q)
  );
  pipe_reg #(.W(TW)) u_tag (
    .clk(CLK), .rst_n(RST), .clr(FLUSH), .en(en),
    .d({Dest_In, src1_In, src2_In}), .q(tag_q)
  );
  pipe_reg #(.W(WORD_W)) u_pc (
    .clk(CLK), .rst_n(RST), .clr(FLUSH), .en(en), .d(PC_In), .q(PC_Out)
  );
  pipe_reg #(.W(4)) u_sr (
    .clk(CLK), .rst_n(RST), .clr(FLUSH), .en(en), .d(SR_In), .q(SR_Out)
  );
  pipe_reg #(.W(1), .CLR_VAL(1'b0)) u_valid (
    .clk(CLK), .rst_n(RST), .clr(FLUSH), .en(en), .d(1'b1), .q(Valid_Out)
  );
  assign {WB_EN_Out, MEM_R_EN_Out, MEM_W_EN_Out, B_Out, S_Out, imm_Out, EXE_CMD_Out} = ctrl_q;
  assign {Val_Rn_Out, Val_Rm_Out} = data_q;
  assign {Shift_operand_Out, Signed_imm_24_Out} = imm_q;
  assign {Dest_Out, src1_Out, src2_Out} = tag_q;
endmodule

// File: tb/tb_id_exe_stage_reg.sv
// tb_id_exe_stage_reg: vector table, reset/async corner sequences and random stream against a reference model
module tb_id_exe_stage_reg;
  typedef struct packed {
    logic        wb, mr, mw, b, s;
    logic [3:0]  cmd;
    logic [31:0] rn, rm;
    logic        imm;
    logic [11:0] sh;
    logic [23:0] si;
    logic [3:0]  dest, s1, s2, sr;
    logic [31:0] pc;
  } fields_t;
  typedef struct packed {
    fields_t f;
    logic    v;
  } exp_t;
  typedef struct {
    logic    fr, fl;
    fields_t in;
    exp_t    e;
    string   nm;
  } vec_t;

  logic CLK = 1'b0, RST = 1'b0, FREEZE = 1'b0, FLUSH = 1'b0;
  logic [31:0] PC_In, Val_Rn_In, Val_Rm_In, PC_Out, Val_Rn_Out, Val_Rm_Out;
  logic WB_EN_In, MEM_R_EN_In, MEM_W_EN_In, B_In, S_In, imm_In;
  logic WB_EN_Out, MEM_R_EN_Out, MEM_W_EN_Out, B_Out, S_Out, imm_Out, Valid_Out;
  logic [3:0] EXE_CMD_In, Dest_In, src1_In, src2_In, SR_In;
  logic [3:0] EXE_CMD_Out, Dest_Out, src1_Out, src2_Out, SR_Out;
  logic [11:0] Shift_operand_In, Shift_operand_Out;
  logic [23:0] Signed_imm_24_In, Signed_imm_24_Out;
  fields_t in_f = '0, out_f, m_f = '0;
  logic m_v = 1'b0;
  exp_t sb[$];
  int compared = 0, mismatched = 0;
  vec_t tab[10];

  always #5 CLK = ~CLK;

  assign {WB_EN_In, MEM_R_EN_In, MEM_W_EN_In, B_In, S_In, EXE_CMD_In, Val_Rn_In, Val_Rm_In, imm_In,
          Shift_operand_In, Signed_imm_24_In, Dest_In, src1_In, src2_In, SR_In, PC_In} = in_f;
  assign out_f = {WB_EN_Out, MEM_R_EN_Out, MEM_W_EN_Out, B_Out, S_Out, EXE_CMD_Out, Val_Rn_Out,
                  Val_Rm_Out, imm_Out, Shift_operand_Out, Signed_imm_24_Out, Dest_Out, src1_Out,
                  src2_Out, SR_Out, PC_Out};

  id_exe_stage_reg dut (
    .CLK(CLK), .RST(RST), .FREEZE(FREEZE), .FLUSH(FLUSH), .PC_In(PC_In),
    .WB_EN_In(WB_EN_In), .MEM_R_EN_In(MEM_R_EN_In), .MEM_W_EN_In(MEM_W_EN_In), .B_In(B_In),
    .S_In(S_In), .EXE_CMD_In(EXE_CMD_In), .Val_Rn_In(Val_Rn_In), .Val_Rm_In(Val_Rm_In),
    .imm_In(imm_In), .Shift_operand_In(Shift_operand_In), .Signed_imm_24_In(Signed_imm_24_In),
    .Dest_In(Dest_In), .src1_In(src1_In), .src2_In(src2_In), .SR_In(SR_In),
    .PC_Out(PC_Out), .WB_EN_Out(WB_EN_Out), .MEM_R_EN_Out(MEM_R_EN_Out),
    .MEM_W_EN_Out(MEM_W_EN_Out), .B_Out(B_Out), .S_Out(S_Out), .EXE_CMD_Out(EXE_CMD_Out),
    .Val_Rn_Out(Val_Rn_Out), .Val_Rm_Out(Val_Rm_Out), .imm_Out(imm_Out),
    .Shift_operand_Out(Shift_operand_Out), .Signed_imm_24_Out(Signed_imm_24_Out),
    .Dest_Out(Dest_Out), .src1_Out(src1_Out), .src2_Out(src2_Out), .SR_Out(SR_Out),
    .Valid_Out(Valid_Out)
  );

  // a bubble must never carry a side-effect enable
  always @(negedge CLK)
    if (RST && !Valid_Out) begin
      compared++;
      if (|{WB_EN_Out, MEM_R_EN_Out, MEM_W_EN_Out, B_Out, S_Out}) begin
        mismatched++;
        $display("FAIL bubble_enables: got %b required 00000 at %0t",
                 {WB_EN_Out, MEM_R_EN_Out, MEM_W_EN_Out, B_Out, S_Out}, $time);
      end
    end

  function automatic fields_t mk(logic [31:0] pc, rn, logic [3:0] dest, cmd, logic wb, mw, b);
    fields_t f;
    f = '0;
    f.pc = pc; f.rn = rn; f.rm = ~rn; f.dest = dest; f.cmd = cmd;
    f.wb = wb; f.mw = mw; f.b = b; f.mr = b; f.s = mw; f.imm = wb ^ b;
    f.sh = pc[11:0]; f.si = rn[23:0]; f.s1 = dest + 4'd1; f.s2 = dest + 4'd2; f.sr = dest ^ cmd;
    return f;
  endfunction

  function automatic fields_t rnd();
    fields_t f;
    for (int i = 0; i < $bits(fields_t); i++) f[i] = 1'($urandom_range(0, 1));
    return f;
  endfunction

  task automatic check(input string nm);
    exp_t g, e;
    g = {out_f, Valid_Out};
    compared++;
    if (sb.size() == 0) begin
      mismatched++;
      $display("FAIL %s: scoreboard empty, got %h", nm, g);
    end else begin
      e = sb.pop_front();
      if (g !== e) begin
        mismatched++;
        $display("FAIL %s: got %h required %h", nm, g, e);
      end
    end
  endtask

  task automatic cycle(input logic fr, fl, input fields_t in, input logic use_m, input exp_t e,
                       input string nm);
    @(negedge CLK);
    FREEZE = fr; FLUSH = fl; in_f = in;
    if (fl) begin m_f = '0; m_v = 1'b0; end
    else if (!fr) begin m_f = in; m_v = 1'b1; end
    sb.push_back(use_m ? exp_t'({m_f, m_v}) : e);
    @(posedge CLK); #1;
    check(nm);
  endtask

  initial begin
    fields_t v1, v2, v3, r;
    v1 = mk(32'h0000_0010, 32'hDEAD_BEEF, 4'h5, 4'h2, 1'b1, 1'b0, 1'b0);
    v2 = mk(32'h0000_0020, 32'h1234_5678, 4'h7, 4'h4, 1'b1, 1'b1, 1'b0);
    v3 = mk(32'h0000_0030, 32'hCAFE_F00D, 4'h9, 4'h3, 1'b1, 1'b1, 1'b1);
    tab[0] = '{1'b0, 1'b0, v1, '{v1, 1'b1}, "load_v1"};
    tab[1] = '{1'b1, 1'b0, v2, '{v1, 1'b1}, "freeze_1"};
    tab[2] = '{1'b1, 1'b0, v2, '{v1, 1'b1}, "freeze_2"};
    tab[3] = '{1'b1, 1'b0, v3, '{v1, 1'b1}, "freeze_3"};
    tab[4] = '{1'b0, 1'b0, v2, '{v2, 1'b1}, "unfreeze_v2"};
    tab[5] = '{1'b0, 1'b1, v3, '{'0, 1'b0}, "flush"};
    tab[6] = '{1'b1, 1'b1, v3, '{'0, 1'b0}, "flush_over_freeze"};
    tab[7] = '{1'b1, 1'b0, v3, '{'0, 1'b0}, "freeze_bubble"};
    tab[8] = '{1'b0, 1'b0, v3, '{v3, 1'b1}, "load_v3"};
    tab[9] = '{1'b1, 1'b1, v1, '{'0, 1'b0}, "flush_valid_frozen"};
    // reset held across clock edges with inputs toggling
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      in_f = rnd(); FREEZE = 1'($urandom_range(0, 1)); FLUSH = 1'($urandom_range(0, 1));
      sb.push_back('0);
      @(posedge CLK); #1;
      check("reset_hold");
    end
    RST = 1'b1;
    r = rnd();
    cycle(1'b0, 1'b0, r, 1'b0, '{r, 1'b1}, "first_load_after_reset");
    for (int i = 0; i < 10; i++) cycle(tab[i].fr, tab[i].fl, tab[i].in, 1'b0, tab[i].e, tab[i].nm);
    // async reset between edges, mid-freeze then mid-flush
    for (int k = 0; k < 2; k++) begin
      cycle(1'b0, 1'b0, v2, 1'b0, '{v2, 1'b1}, "reload");
      #2;
      FREEZE = (k == 0); FLUSH = (k == 1); RST = 1'b0;
      #1;
      m_f = '0; m_v = 1'b0;
      sb.push_back('0);
      check(k == 0 ? "async_rst_freeze" : "async_rst_flush");
      @(negedge CLK);
      RST = 1'b1; FREEZE = 1'b0; FLUSH = 1'b1;
    end
    cycle(1'b0, 1'b1, v1, 1'b0, '{'0, 1'b0}, "bubble_after_reset");
    for (int i = 0; i < 1000; i++)
      cycle($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 2, rnd(), 1'b1, '0, "random");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
